// File: rtl/axi_slv_mem.sv
// axi_slv_mem
//   AXI4 slave memory responder backed by a word-addressed internal RAM.
//   The write and read channels run independently, each with at most one
//   burst in flight. Supports FIXED/INCR/WRAP bursts, narrow transfers with
//   byte strobes, and DECERR/SLVERR error responses.
//
// Parameters
//   ID_W        transaction id width
//   ADDR_W      AXI address width
//   DATA_W      data width (32 or 64)
//   MEM_ADDR_W  backing store holds 2**MEM_ADDR_W bytes
//
// Ports
//   aclk, aresetn                          clock, async active-low reset
//   s_axi_aw*                              write address channel
//   s_axi_w*                               write data channel
//   s_axi_b*                               write response channel
//   s_axi_ar*                              read address channel
//   s_axi_r*                               read data channel
module axi_slv_mem #(
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 12
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int BYTES = DATA_W / 8;
  localparam int SZ_LG = $clog2(BYTES);
  localparam int IDX_W = MEM_ADDR_W - SZ_LG;
  localparam int WORDS = 2 ** IDX_W;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Reserved burst type, a WRAP with an unsupported length, or a beat wider
  // than the bus: the burst runs its full beat count but never touches RAM.
  function automatic logic illegal(input logic [1:0] bt, input logic [7:0] len,
                                   input logic [2:0] sz);
    logic wrap_ok;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (bt == 2'b11) || ((bt == BURST_WRAP) && !wrap_ok) || (int'(sz) > SZ_LG);
  endfunction

  // Address of the beat following 'a'. Illegal bursts simply step like INCR;
  // their addresses only matter for the out-of-range check.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0] sz,
                                                  input logic [7:0] len,
                                                  input logic [1:0] bt,
                                                  input logic ill);
    logic [ADDR_W-1:0] step, cont, lower, nxt;
    step  = ADDR_W'(1) << sz;
    cont  = ADDR_W'({1'b0, len} + 9'd1) << sz;
    lower = a & ~(cont - ADDR_W'(1));
    nxt   = a + step;
    if (!ill && bt == BURST_FIXED) return a;
    if (!ill && bt == BURST_WRAP && nxt >= lower + cont) return lower;
    return nxt;
  endfunction

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return |a[ADDR_W-1:MEM_ADDR_W];
  endfunction

  logic [DATA_W-1:0] mem [WORDS];

  // ---------------------------------------------------------------- write
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  wstate_t           w_state;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len;
  logic [7:0]        w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_ill;
  logic              w_dec;
  logic              w_lastbad;

  logic              w_beat, w_oor, w_last, w_we, w_lastbad_now;
  logic [IDX_W-1:0]  w_idx;

  always_comb begin
    w_beat        = s_axi_wvalid && s_axi_wready;
    w_oor         = out_of_range(w_addr);
    w_last        = (w_cnt == w_len);
    w_we          = w_beat && !w_oor && !w_ill;
    w_idx         = w_addr[MEM_ADDR_W-1:SZ_LG];
    w_lastbad_now = w_lastbad || (s_axi_wlast != w_last);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= RESP_OKAY;
      w_id          <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_ill         <= 1'b0;
      w_dec         <= 1'b0;
      w_lastbad     <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            w_id          <= s_axi_awid;
            w_addr        <= s_axi_awaddr;
            w_len         <= s_axi_awlen;
            w_size        <= s_axi_awsize;
            w_burst       <= s_axi_awburst;
            w_ill         <= illegal(s_axi_awburst, s_axi_awlen, s_axi_awsize);
            w_cnt         <= '0;
            w_dec         <= 1'b0;
            w_lastbad     <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_cnt     <= w_cnt + 8'd1;
            w_addr    <= next_addr(w_addr, w_size, w_len, w_burst, w_ill);
            w_dec     <= w_dec || w_oor;
            w_lastbad <= w_lastbad_now;
            if (w_last) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= w_id;
              if (w_dec || w_oor)              s_axi_bresp <= RESP_DECERR;
              else if (w_ill || w_lastbad_now) s_axi_bresp <= RESP_SLVERR;
              else                             s_axi_bresp <= RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // RAM contents survive reset; only in-range beats of legal bursts land.
  always_ff @(posedge aclk) begin
    if (w_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- read
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  rstate_t           r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic              r_ill;

  // One RAM read port: the AR address in idle, otherwise the next beat.
  logic              ld_ill, ld_oor;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] ld_data;
  logic [1:0]        ld_resp;

  always_comb begin
    if (r_state == R_IDLE) begin
      ld_ill = illegal(s_axi_arburst, s_axi_arlen, s_axi_arsize);
      ld_oor = out_of_range(s_axi_araddr);
      ld_idx = s_axi_araddr[MEM_ADDR_W-1:SZ_LG];
    end else begin
      ld_ill = r_ill;
      ld_oor = out_of_range(r_addr);
      ld_idx = r_addr[MEM_ADDR_W-1:SZ_LG];
    end
    ld_data = (ld_oor || ld_ill) ? '0 : mem[ld_idx];
    ld_resp = ld_oor ? RESP_DECERR : (ld_ill ? RESP_SLVERR : RESP_OKAY);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_ill         <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            r_len         <= s_axi_arlen;
            r_size        <= s_axi_arsize;
            r_burst       <= s_axi_arburst;
            r_ill         <= ld_ill;
            r_cnt         <= '0;
            r_addr        <= next_addr(s_axi_araddr, s_axi_arsize, s_axi_arlen,
                                       s_axi_arburst, ld_ill);
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rid     <= s_axi_arid;
            s_axi_rdata   <= ld_data;
            s_axi_rresp   <= ld_resp;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              s_axi_rdata <= ld_data;
              s_axi_rresp <= ld_resp;
              s_axi_rlast <= (r_cnt + 8'd1 == r_len);
              r_cnt       <= r_cnt + 8'd1;
              r_addr      <= next_addr(r_addr, r_size, r_len, r_burst, r_ill);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slv_mem.sv
// tb_axi_slv_mem
//   Directed bench for axi_slv_mem: burst types, narrow writes, error
//   responses, read back-pressure and mid-burst reset.
module tb_axi_slv_mem;

  localparam int TMO = 50;

  logic        aclk;
  logic        aresetn;
  logic [3:0]  s_axi_awid;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [3:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  axi_slv_mem dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  logic [3:0]  rid_got;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic axi_wr(input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] burst, input int last_beat,
                        output logic [1:0] resp, output logic [3:0] bid_o);
    int t;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    t = 0;
    while (!s_axi_awready && t < TMO) begin @(posedge aclk); #1; t++; end
    chk("aw_ready", s_axi_awready, 1);
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0;
    chk("aw_wready", s_axi_wready, 1);
    chk("aw_busy", s_axi_awready, 0);
    for (int b = 0; b <= int'(len); b++) begin
      s_axi_wdata = wd[b]; s_axi_wstrb = ws[b];
      s_axi_wlast = (b == last_beat); s_axi_wvalid = 1'b1;
      t = 0;
      while (!s_axi_wready && t < TMO) begin @(posedge aclk); #1; t++; end
      @(posedge aclk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    chk("b_lat", s_axi_bvalid, 1);
    s_axi_bready = 1'b1;
    t = 0;
    while (!s_axi_bvalid && t < TMO) begin @(posedge aclk); #1; t++; end
    resp = s_axi_bresp; bid_o = s_axi_bid;
    @(posedge aclk); #1;
    s_axi_bready = 1'b0;
    chk("b_done", s_axi_bvalid, 0);
    chk("b_awready", s_axi_awready, 1);
  endtask

  task automatic ar_issue(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst);
    int t;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    t = 0;
    while (!s_axi_arready && t < TMO) begin @(posedge aclk); #1; t++; end
    chk("ar_ready", s_axi_arready, 1);
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic axi_rd(input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] burst);
    int t;
    ar_issue(id, addr, len, size, burst);
    chk("ar_lat", s_axi_rvalid, 1);
    s_axi_rready = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      t = 0;
      while (!s_axi_rvalid && t < TMO) begin @(posedge aclk); #1; t++; end
      rd[b] = s_axi_rdata; rr[b] = s_axi_rresp; rl[b] = s_axi_rlast;
      rid_got = s_axi_rid;
      @(posedge aclk); #1;
    end
    s_axi_rready = 1'b0;
    chk("r_done", s_axi_rvalid, 0);
    chk("r_arready", s_axi_arready, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [1:0]  resp;
    logic [3:0]  bidv;
    logic [31:0] exp4 [4];
    logic [31:0] held;
    logic        stalled;
    int          k, cyc;

    aresetn = 1'b0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

    // reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_wready", s_axi_wready, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_rlast", s_axi_rlast, 0);
    chk("rst_bresp", s_axi_bresp, 0);
    chk("rst_rresp", s_axi_rresp, 0);
    chk("rst_bid", s_axi_bid, 0);
    chk("rst_rid", s_axi_rid, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("rel_awready_pre", s_axi_awready, 0);
    @(posedge aclk); #1;
    chk("rel_awready", s_axi_awready, 1);
    chk("rel_arready", s_axi_arready, 1);

    // INCR write / read back
    wd[0] = 32'hdeadbeef; wd[1] = 32'hc0decafe; wd[2] = 32'hbabeb00b;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
    axi_wr(4'd3, 32'h100, 8'd2, 3'd2, 2'b01, 2, resp, bidv);
    chk("incr_bresp", resp, 2'b00);
    chk("incr_bid", bidv, 4'd3);
    axi_rd(4'd5, 32'h100, 8'd2, 3'd2, 2'b01);
    chk("incr_rid", rid_got, 4'd5);
    for (int b = 0; b < 3; b++) begin
      chk("incr_rdata", rd[b], wd[b]);
      chk("incr_rresp", rr[b], 2'b00);
      chk("incr_rlast", rl[b], (b == 2) ? 1'b1 : 1'b0);
    end

    // WRAP write len=3 from 0x108 lands at 108,10C,100,104
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
    ws[3] = 4'hF;
    axi_wr(4'd1, 32'h108, 8'd3, 3'd2, 2'b10, 3, resp, bidv);
    chk("wrap_bresp", resp, 2'b00);
    axi_rd(4'd2, 32'h100, 8'd3, 3'd2, 2'b01);
    exp4[0] = 32'd3; exp4[1] = 32'd4; exp4[2] = 32'd1; exp4[3] = 32'd2;
    for (int b = 0; b < 4; b++) chk("wrap_rdata", rd[b], exp4[b]);

    // narrow byte write into an existing word
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    axi_wr(4'd0, 32'h200, 8'd0, 3'd2, 2'b01, 0, resp, bidv);
    chk("narrow_init_bresp", resp, 2'b00);
    wd[0] = 32'h0000AB00; ws[0] = 4'b0010;
    axi_wr(4'd0, 32'h201, 8'd0, 3'd0, 2'b01, 0, resp, bidv);
    chk("narrow_bresp", resp, 2'b00);
    axi_rd(4'd0, 32'h200, 8'd0, 3'd2, 2'b01);
    chk("narrow_rdata", rd[0], 32'h1122AB44);

    // write straddling the top of memory -> DECERR, in-range beat kept
    wd[0] = 32'hA5A5A5A5; wd[1] = 32'h5A5A5A5A; ws[0] = 4'hF; ws[1] = 4'hF;
    axi_wr(4'd7, 32'hFFC, 8'd1, 3'd2, 2'b01, 1, resp, bidv);
    chk("dec_bresp", resp, 2'b11);
    axi_rd(4'd0, 32'hFFC, 8'd0, 3'd2, 2'b01);
    chk("dec_kept", rd[0], 32'hA5A5A5A5);
    chk("dec_kept_resp", rr[0], 2'b00);
    axi_rd(4'd0, 32'h1000, 8'd0, 3'd2, 2'b01);
    chk("dec_rdata", rd[0], 32'h0);
    chk("dec_rresp", rr[0], 2'b11);
    chk("dec_rlast", rl[0], 1'b1);

    // reserved burst type on read -> SLVERR on both beats, zero data
    axi_rd(4'd4, 32'h100, 8'd1, 3'd2, 2'b11);
    for (int b = 0; b < 2; b++) begin
      chk("slv_rresp", rr[b], 2'b10);
      chk("slv_rdata", rd[b], 32'h0);
    end
    chk("slv_rlast", rl[1], 1'b1);

    // oversize read -> SLVERR
    axi_rd(4'd4, 32'h100, 8'd0, 3'd3, 2'b01);
    chk("size_rresp", rr[0], 2'b10);

    // early wlast -> SLVERR
    wd[0] = 32'h1; wd[1] = 32'h2;
    axi_wr(4'd9, 32'h300, 8'd1, 3'd2, 2'b01, 0, resp, bidv);
    chk("wlast_bresp", resp, 2'b10);
    chk("wlast_bid", bidv, 4'd9);

    // illegal WRAP length: SLVERR and RAM untouched
    wd[0] = 32'h11111111; ws[0] = 4'hF;
    axi_wr(4'd0, 32'h400, 8'd0, 3'd2, 2'b01, 0, resp, bidv);
    wd[0] = 32'hFFFFFFFF; wd[1] = 32'hFFFFFFFF; wd[2] = 32'hFFFFFFFF;
    ws[1] = 4'hF; ws[2] = 4'hF;
    axi_wr(4'd0, 32'h400, 8'd2, 3'd2, 2'b10, 2, resp, bidv);
    chk("badwrap_bresp", resp, 2'b10);
    axi_rd(4'd0, 32'h400, 8'd0, 3'd2, 2'b01);
    chk("badwrap_untouched", rd[0], 32'h11111111);

    // back-pressure: rready 1,0,0,1,... over a 4-beat read
    ar_issue(4'd6, 32'h100, 8'd3, 3'd2, 2'b01);
    k = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (k < 4 && cyc < 40) begin
      s_axi_rready = (cyc % 3 == 0);
      if (s_axi_rvalid) begin
        if (stalled) chk("stall_hold", s_axi_rdata, held);
        if (s_axi_rready) begin
          chk("stall_beat", s_axi_rdata, exp4[k]);
          chk("stall_rlast", s_axi_rlast, (k == 3) ? 1'b1 : 1'b0);
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = s_axi_rdata;
        end
      end
      @(posedge aclk); #1;
      cyc++;
    end
    s_axi_rready = 1'b0;
    chk("stall_count", k, 4);
    chk("stall_cycles", cyc, 10);

    // reset in the middle of a read burst
    ar_issue(4'd2, 32'h100, 8'd7, 3'd2, 2'b01);
    chk("mid_rvalid_pre", s_axi_rvalid, 1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("mid_rvalid", s_axi_rvalid, 0);
    chk("mid_arready", s_axi_arready, 0);
    chk("mid_rlast", s_axi_rlast, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("mid_arready_pre", s_axi_arready, 0);
    @(posedge aclk); #1;
    chk("mid_arready_post", s_axi_arready, 1);
    axi_rd(4'd0, 32'h100, 8'd0, 3'd2, 2'b01);
    chk("mid_ram_kept", rd[0], 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
